fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, which is the first fetch address after reset.
REQ-002 SHALL have parameter NOP_INST, default 32'h0000_0013 (addi x0,x0,0), which is the value of if_id_inst when no instruction is valid.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port imem_req, output, 1 bit: fetch request to instruction memory.
REQ-006 SHALL have port imem_addr, output, 32 bits: fetch address, word aligned in normal flow.
REQ-007 SHALL have port imem_rdata, input, 32 bits: instruction word, meaningful only when imem_valid=1.
REQ-008 SHALL have port imem_valid, input, 1 bit: response strobe; it may assert in the request cycle or any later cycle.
REQ-009 SHALL have port id_stall, input, 1 bit: decode cannot accept a new instruction.
REQ-010 SHALL have port redirect, input, 1 bit: taken branch/jump from execute; flush and refetch.
REQ-011 SHALL have port redirect_pc, input, 32 bits: target address for a redirect.
REQ-012 SHALL have port if_id_inst, output, 32 bits: registered instruction to decode and imm_gen.
REQ-013 SHALL have port if_id_pc, output, 32 bits: PC of if_id_inst.
REQ-014 SHALL have port if_id_valid, output, 1 bit: if_id_inst/if_id_pc hold a real instruction.

Function
REQ-015 SHALL implement FSM states FETCH (request outstanding), HOLD (response buffered, decode stalled), and DROP (discarding a response to a flushed request).
REQ-016 SHALL, in FETCH, drive imem_req=1 and imem_addr=pc, holding both stable until imem_valid.
REQ-017 SHALL, in FETCH with imem_valid=1 and id_stall=0, load if_id_inst<=imem_rdata, if_id_pc<=pc, if_id_valid<=1 and pc<=pc+4 (mod 2^32, wrap 32'hFFFF_FFFC->0), and stay in FETCH, sustaining 1 instruction/cycle with zero-wait memory.
REQ-018 SHALL, in FETCH with imem_valid=1 and id_stall=1, capture imem_rdata into the skid buffer, set pc<=pc+4, enter HOLD, and leave the IF/ID register unchanged.
REQ-019 SHALL, in HOLD, drive imem_req=0; on id_stall=0 it SHALL move the buffer into the IF/ID register with if_id_valid=1 and return to FETCH.
REQ-020 SHALL, when id_stall=1, hold if_id_inst, if_id_pc and if_id_valid unchanged, subject to REQ-021.
REQ-021 SHALL treat redirect=1 as having priority over id_stall and imem_valid: at the next edge if_id_valid<=0, if_id_inst<=NOP_INST, pc<=redirect_pc, and the skid buffer is cleared.
REQ-022 SHALL, on a redirect in FETCH with imem_valid=0, enter DROP with imem_req=0; on a later imem_valid it SHALL discard the data and enter FETCH at redirect_pc.
REQ-023 SHALL, on a redirect coincident with imem_valid, discard the data and go straight to FETCH with imem_addr=redirect_pc on the next cycle.
REQ-024 SHALL, on a redirect in DROP, update pc only and keep waiting for the single outstanding response.
REQ-025 SHALL never have more than one memory request outstanding.

Reset
REQ-026 SHALL, while rst_n=0, force pc=RESET_PC, state=FETCH, imem_req=0, imem_addr=RESET_PC, if_id_inst=NOP_INST, if_id_pc=0, if_id_valid=0, and the skid buffer empty.
REQ-027 SHALL assert imem_req=1 in the first cycle after rst_n deasserts; reset mid-transfer discards any pending response.

Configuration
REQ-028 SHALL provide macro FETCH_MISALIGN_CHECK_EN; when defined, a redirect with redirect_pc[1:0]!=0 SHALL produce no memory request and SHALL instead present if_id_valid=1, if_id_inst=NOP_INST, and an extra output if_id_misalign=1 (reset 0) until the next redirect; when undefined, the port is absent and redirect_pc[1:0] are ignored (forced to 0).

Structure
REQ-029 SHALL take the state encoding, NOP_INST default and RESET_PC default from the shared package riscv_pkg.
REQ-030 SHALL place the one-entry buffer in sub-module fetch_skid_buf (load, unload, clear, 32-bit data+pc).

Verification
REQ-031 SHALL check: reset release with zero-wait memory returning sequential words -> if_id_pc = 0,4,8,12 on consecutive cycles with if_id_valid=1.
REQ-032 SHALL check: id_stall=1 for 3 cycles while imem_valid pulses once -> imem_req drops, IF/ID is frozen, and the buffered word appears with the correct PC on the first unstalled cycle.
REQ-033 SHALL check: redirect to 0x100 while a 3-cycle-latency response is pending -> the late response is discarded, the next imem_addr is 0x100, and no wrong-path if_id_valid occurs.
REQ-034 SHALL check: redirect and imem_valid in the same cycle with id_stall=1 -> if_id_valid=0 and the next imem_addr is redirect_pc.
REQ-035 SHALL check: pc=32'hFFFF_FFFC fetched -> next imem_addr=0; rst_n asserted mid-request -> all outputs take their REQ-026 values immediately.
REQ-036 SHALL check, with FETCH_MISALIGN_CHECK_EN: redirect to 0x102 -> if_id_misalign=1 and no imem_req is issued.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions.
//   RESET_PC_DEF / NOP_INST_DEF : default first fetch address and bubble instruction
//   fetch_state_t               : fetch FSM encoding
//   pc_next()                   : sequential PC increment (wraps modulo 2^32)
package riscv_pkg;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam logic [31:0] NOP_INST_DEF = 32'h0000_0013;   // addi x0,x0,0

    typedef enum logic [1:0] {
        ST_FETCH    = 2'd0,   // request outstanding
        ST_HOLD     = 2'd1,   // response parked in skid buffer, decode stalled
        ST_DROP     = 2'd2,   // waiting out a response to a flushed request
        ST_MISALIGN = 2'd3    // parked on a misaligned target until redirected
    } fetch_state_t;

    function automatic logic [31:0] pc_next(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry skid buffer holding an instruction word and its PC while decode
// is stalled.
//   clk, rst_n          : clock, asynchronous active-low reset
//   load                : capture load_inst/load_pc, mark full
//   unload              : mark empty (data consumed by the caller)
//   clear               : flush, dominates load and unload
//   load_inst, load_pc  : incoming entry
//   buf_inst, buf_pc    : stored entry
//   buf_full            : entry valid
module fetch_skid_buf (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        unload,
    input  logic        clear,
    input  logic [31:0] load_inst,
    input  logic [31:0] load_pc,
    output logic [31:0] buf_inst,
    output logic [31:0] buf_pc,
    output logic        buf_full
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_full <= 1'b0;
        end else if (clear) begin
            buf_full <= 1'b0;
        end else if (load) begin
            buf_full <= 1'b1;
        end else if (unload) begin
            buf_full <= 1'b0;
        end
    end

    // Payload needs no reset: it is only observed while buf_full is set.
    always_ff @(posedge clk) begin
        if (load && !clear) begin
            buf_inst <= load_inst;
            buf_pc   <= load_pc;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage with IF/ID pipeline register.
// Keeps at most one instruction-memory request in flight, parks a response in
// a one-entry skid buffer when decode stalls, and discards responses that
// belong to requests flushed by a redirect.
//   clk, rst_n                  : clock, asynchronous active-low reset
//   imem_req, imem_addr         : fetch request / address to instruction memory
//   imem_rdata, imem_valid      : response data / strobe
//   id_stall                    : decode cannot accept an instruction
//   redirect, redirect_pc       : flush and refetch from redirect_pc
//   if_id_inst/pc/valid         : IF/ID register to decode
//   if_id_misalign              : misaligned redirect target (only with
//                                 FETCH_MISALIGN_CHECK_EN defined; otherwise
//                                 redirect_pc[1:0] are forced to zero)
module fetch_stage
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter logic [31:0] NOP_INST = NOP_INST_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_valid,
    input  logic        id_stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] if_id_inst,
    output logic [31:0] if_id_pc,
    output logic        if_id_valid
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    output logic        if_id_misalign
`endif
);

    fetch_state_t state_q, state_d, redir_state;
    logic [31:0]  pc_q;
    logic [31:0]  redir_tgt;
    logic         redir_bad;
    logic         misalign_q;
    logic         fetch_accept;
    logic         skid_load, skid_unload, skid_full;
    logic [31:0]  skid_inst, skid_pc;

`ifdef FETCH_MISALIGN_CHECK_EN
    assign redir_tgt = redirect_pc;
    assign redir_bad = |redirect_pc[1:0];
    assign if_id_misalign = misalign_q;
`else
    assign redir_tgt = redirect_pc & 32'hFFFF_FFFC;
    assign redir_bad = 1'b0;
`endif

    assign redir_state  = redir_bad ? ST_MISALIGN : ST_FETCH;
    // A response in FETCH is only used if no redirect flushes it this cycle.
    assign fetch_accept = (state_q == ST_FETCH) && imem_valid && !redirect;
    assign skid_load    = fetch_accept && id_stall;
    assign skid_unload  = (state_q == ST_HOLD) && !redirect && !id_stall && skid_full;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_FETCH: begin
                if (redirect) begin
                    // Without a response the request is still in flight and
                    // must be waited out before a new one may issue.
                    state_d = imem_valid ? redir_state : ST_DROP;
                end else if (imem_valid && id_stall) begin
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (redirect) begin
                    state_d = redir_state;
                end else if (!id_stall) begin
                    state_d = ST_FETCH;
                end
            end
            ST_DROP: begin
                // A redirect here only retargets pc; exit waits for the response.
                if (imem_valid) begin
                    if (redirect) begin
                        state_d = redir_state;
                    end else begin
                        state_d = misalign_q ? ST_MISALIGN : ST_FETCH;
                    end
                end
            end
            ST_MISALIGN: begin
                if (redirect) begin
                    state_d = redir_state;
                end
            end
            default: state_d = ST_FETCH;
        endcase
    end

    // Output logic; rst_n gating keeps the request low throughout reset.
    always_comb begin
        imem_req  = rst_n && (state_q == ST_FETCH);
        imem_addr = pc_q;
    end

    // PC and IF/ID register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q        <= RESET_PC;
            if_id_inst  <= NOP_INST;
            if_id_pc    <= 32'h0000_0000;
            if_id_valid <= 1'b0;
            misalign_q  <= 1'b0;
        end else if (redirect) begin
            pc_q        <= redir_tgt;
            if_id_inst  <= NOP_INST;
            if_id_pc    <= redir_tgt;
            if_id_valid <= redir_bad;
            misalign_q  <= redir_bad;
        end else begin
            if (fetch_accept) begin
                pc_q <= pc_next(pc_q);
            end
            if (fetch_accept && !id_stall) begin
                if_id_inst  <= imem_rdata;
                if_id_pc    <= pc_q;
                if_id_valid <= 1'b1;
            end else if (skid_unload) begin
                if_id_inst  <= skid_inst;
                if_id_pc    <= skid_pc;
                if_id_valid <= 1'b1;
            end else if ((state_q == ST_FETCH) && !id_stall) begin
                // Decode took the current entry and nothing replaced it.
                if_id_inst  <= NOP_INST;
                if_id_valid <= 1'b0;
            end
        end
    end

    fetch_skid_buf u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (skid_load),
        .unload    (skid_unload),
        .clear     (redirect),
        .load_inst (imem_rdata),
        .load_pc   (pc_q),
        .buf_inst  (skid_inst),
        .buf_pc    (skid_pc),
        .buf_full  (skid_full)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Testbench for fetch_stage: instruction-memory model with programmable
// latency, decode-side scoreboard of delivered instructions, and directed
// checks of reset, stall, redirect, wrap and (optionally) misalign behaviour.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_valid;
    logic        id_stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] if_id_inst;
    logic [31:0] if_id_pc;
    logic        if_id_valid;
`ifdef FETCH_MISALIGN_CHECK_EN
    logic        if_id_misalign;
`endif

    fetch_stage dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .imem_valid  (imem_valid),
        .id_stall    (id_stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .if_id_inst  (if_id_inst),
        .if_id_pc    (if_id_pc),
        .if_id_valid (if_id_valid)
`ifdef FETCH_MISALIGN_CHECK_EN
        ,
        .if_id_misalign (if_id_misalign)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    bit          sb_en    = 1'b1;

    // Memory model state
    bit          outst    = 1'b0;
    bit          flushed  = 1'b0;
    int          lat      = 0;
    int          cnt      = 0;
    logic [31:0] raddr    = '0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[31:2], 2'b11} ^ 32'hA500_0000;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    // One clock cycle: called #1 after a rising edge with inputs set up.
    task automatic step();
        bit   started;
        exp_t e;
        started = 1'b0;
        if (rst_n && !outst && imem_req) begin
            outst   = 1'b1;
            flushed = 1'b0;
            cnt     = lat;
            raddr   = imem_addr;
            started = 1'b1;
        end
        if (outst && cnt == 0) begin
            imem_valid = 1'b1;
            imem_rdata = mem_word(raddr);
        end else begin
            imem_valid = 1'b0;
            imem_rdata = 32'hDEAD_BEEF;
            if (outst) cnt--;
        end
        @(negedge clk);
        if (outst && imem_req && !started)
            check_eq("addr_stable", imem_addr, raddr);
        if (sb_en && !id_stall) begin
            if (exp_q.size() == 0) begin
                check_eq("spurious_valid", {31'b0, if_id_valid}, 32'd0);
            end else if (if_id_valid) begin
                e = exp_q.pop_front();
                check_eq("sb_pc", if_id_pc, e.pc);
                check_eq("sb_inst", if_id_inst, e.inst);
            end
        end
        if (imem_valid && outst) begin
            if (!flushed && !redirect && sb_en) begin
                e.pc   = raddr;
                e.inst = mem_word(raddr);
                exp_q.push_back(e);
            end
            outst   = 1'b0;
            flushed = 1'b0;
        end else if (redirect && outst) begin
            flushed = 1'b1;
        end
        if (redirect) exp_q.delete();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_req"},   {31'b0, imem_req},    32'd0);
        check_eq({tag, "_addr"},  imem_addr,            32'h0);
        check_eq({tag, "_inst"},  if_id_inst,           NOP);
        check_eq({tag, "_pc"},    if_id_pc,             32'h0);
        check_eq({tag, "_valid"}, {31'b0, if_id_valid}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        rst_n       = 1'b0;
        imem_valid  = 1'b0;
        imem_rdata  = '0;
        id_stall    = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");

        // Reset release with zero-wait memory: sequential stream
        rst_n = 1'b1;
        #1;
        check_eq("rel_req", {31'b0, imem_req}, 32'd1);
        check_eq("rel_addr", imem_addr, 32'h0);
        lat = 0;
        for (int k = 0; k < 4; k++) begin
            step();
            check_eq("seq_pc", if_id_pc, 32'(4 * k));
            check_eq("seq_valid", {31'b0, if_id_valid}, 32'd1);
        end

        // Stall for three cycles; one response parked in the skid buffer
        id_stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check_eq("stall_req", {31'b0, imem_req}, 32'd0);
            check_eq("stall_pc_frozen", if_id_pc, 32'd12);
            check_eq("stall_valid", {31'b0, if_id_valid}, 32'd1);
        end
        id_stall = 1'b0;
        step();
        check_eq("unstall_pc", if_id_pc, 32'd16);
        check_eq("unstall_inst", if_id_inst, mem_word(32'd16));
        check_eq("unstall_addr", imem_addr, 32'd20);

        // Redirect while a 3-cycle-latency response is pending
        lat = 3;
        step();
        redirect    = 1'b1;
        redirect_pc = 32'h100;
        step();
        redirect = 1'b0;
        check_eq("drop_req", {31'b0, imem_req}, 32'd0);
        check_eq("drop_valid", {31'b0, if_id_valid}, 32'd0);
        lat  = 0;
        seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            if (imem_req) begin
                seen = 1'b1;
                check_eq("redir_addr", imem_addr, 32'h100);
            end else begin
                step();
            end
        end
        check_eq("redir_req_seen", {31'b0, seen}, 32'd1);
        repeat (3) step();

        // Redirect coincident with imem_valid while decode is stalled
        id_stall    = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h200;
        step();
        redirect = 1'b0;
        id_stall = 1'b0;
        check_eq("coinc_valid", {31'b0, if_id_valid}, 32'd0);
        check_eq("coinc_addr", imem_addr, 32'h200);
        check_eq("coinc_req", {31'b0, imem_req}, 32'd1);
        step();
        check_eq("coinc_pc", if_id_pc, 32'h200);
        repeat (2) step();

        // Misaligned redirect target
        redirect    = 1'b1;
        redirect_pc = 32'h102;
        step();
        redirect = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
        sb_en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check_eq("mis_flag", {31'b0, if_id_misalign}, 32'd1);
            check_eq("mis_req", {31'b0, imem_req}, 32'd0);
            check_eq("mis_valid", {31'b0, if_id_valid}, 32'd1);
            check_eq("mis_inst", if_id_inst, NOP);
            step();
        end
        redirect    = 1'b1;
        redirect_pc = 32'h300;
        step();
        redirect = 1'b0;
        sb_en    = 1'b1;
        check_eq("mis_clear", {31'b0, if_id_misalign}, 32'd0);
        check_eq("mis_exit_addr", imem_addr, 32'h300);
`else
        check_eq("lowbits_ignored_addr", imem_addr, 32'h100);
        check_eq("lowbits_req", {31'b0, imem_req}, 32'd1);
`endif
        repeat (2) step();

        // PC wrap at the top of the address space
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        step();
        redirect = 1'b0;
        check_eq("wrap_addr_top", imem_addr, 32'hFFFF_FFFC);
        step();
        check_eq("wrap_addr_zero", imem_addr, 32'h0);
        check_eq("wrap_if_pc_top", if_id_pc, 32'hFFFF_FFFC);
        step();
        check_eq("wrap_if_pc_zero", if_id_pc, 32'h0);

        // Reset asserted mid-request
        lat = 3;
        step();
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        outst   = 1'b0;
        flushed = 1'b0;
        exp_q.delete();
        imem_valid = 1'b0;
        @(posedge clk);
        #1;
        check_reset_outputs("midrst_hold");
        rst_n = 1'b1;
        #1;
        check_eq("rerel_req", {31'b0, imem_req}, 32'd1);
        check_eq("rerel_addr", imem_addr, 32'h0);
        lat = 0;
        repeat (2) step();
        check_eq("rerel_pc", if_id_pc, 32'd4);
        repeat (2) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
